// File: rtl/start_signal_pkg.sv
// Shared encodings for the start pulse sequencer: FSM states, control
// register bit positions and status word layout.
package start_signal_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } seq_state_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_AUTO  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_ABORTED = 3;
  localparam int ST_OVERRUN = 4;
  localparam int RUNCNT_LSB = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/start_pulse_sequencer.sv
// Bridges software register writes to an ap_ctrl_hs core: issues ap_start,
// tracks the run, measures latency, applies an optional timeout, reports status.
module start_pulse_sequencer
  import start_signal_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_RUNCNT_W   = 16
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic [C_DATA_WIDTH-1:0] ctrl_reg,
  input  logic                    ctrl_wr,
  input  logic [C_DATA_WIDTH-1:0] param_reg,
  input  logic [C_DATA_WIDTH-1:0] timeout_reg,
  output logic [C_DATA_WIDTH-1:0] status,
  output logic [C_DATA_WIDTH-1:0] cycle_cnt,
  output logic                    irq,
  output logic                    ap_start,
  output logic [C_DATA_WIDTH-1:0] ap_param,
  input  logic                    ap_ready,
  input  logic                    ap_done
);

  seq_state_e state, state_d;

  logic ap_start_d, irq_d, latch_param, clr_cnt, en_cnt, clr_sticky, inc_run;
  logic set_done, set_timeout, set_aborted, set_overrun;
  logic done_f, timeout_f, aborted_f, overrun_f;
  logic [C_RUNCNT_W-1:0] run_cnt;

  logic start_req, abort_req, timeout_hit, done_hit;
  logic unused_ctrl_bits;

  assign unused_ctrl_bits = ^ctrl_reg[C_DATA_WIDTH-1:3];

  // Abort takes precedence over start when both bits are written together.
  assign start_req   = ctrl_wr && ctrl_reg[CTRL_START] && !ctrl_reg[CTRL_ABORT];
  assign abort_req   = ctrl_wr && ctrl_reg[CTRL_ABORT];
  assign timeout_hit = (timeout_reg != '0) &&
                       (cycle_cnt == (timeout_reg - C_DATA_WIDTH'(1)));
  assign done_hit    = ap_done && ((state == S_RUN) || ap_ready);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    ap_start_d  = ap_start;
    irq_d       = 1'b0;
    latch_param = 1'b0;
    clr_cnt     = 1'b0;
    en_cnt      = 1'b0;
    clr_sticky  = 1'b0;
    inc_run     = 1'b0;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    set_aborted = 1'b0;
    set_overrun = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          latch_param = 1'b1;
          clr_sticky  = 1'b1;
          clr_cnt     = 1'b1;
          ap_start_d  = 1'b1;
          state_d     = S_START;
        end
      end
      S_START, S_RUN: begin
        en_cnt = 1'b1;
        if (start_req) set_overrun = 1'b1;
        // A completion arriving on the timeout cycle still counts as done.
        if (done_hit) begin
          set_done = 1'b1;
          inc_run  = 1'b1;
          irq_d    = 1'b1;
          if (ctrl_reg[CTRL_AUTO]) begin
            latch_param = 1'b1;
            clr_cnt     = 1'b1;
            ap_start_d  = 1'b1;
            state_d     = S_START;
          end else begin
            ap_start_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else if (abort_req) begin
          set_aborted = 1'b1;
          ap_start_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          irq_d       = 1'b1;
          ap_start_d  = 1'b0;
          state_d     = S_IDLE;
        end else if ((state == S_START) && ap_ready) begin
          ap_start_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      default: begin
        ap_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ap_start  <= 1'b0;
      irq       <= 1'b0;
      ap_param  <= '0;
      run_cnt   <= '0;
      done_f    <= 1'b0;
      timeout_f <= 1'b0;
      aborted_f <= 1'b0;
      overrun_f <= 1'b0;
    end else begin
      ap_start <= ap_start_d;
      irq      <= irq_d;
      if (latch_param) ap_param <= param_reg;
      if (inc_run)     run_cnt  <= run_cnt + C_RUNCNT_W'(1);
      if (clr_sticky) begin
        done_f    <= 1'b0;
        timeout_f <= 1'b0;
        aborted_f <= 1'b0;
        overrun_f <= 1'b0;
      end
      if (set_done)    done_f    <= 1'b1;
      if (set_timeout) timeout_f <= 1'b1;
      if (set_aborted) aborted_f <= 1'b1;
      if (set_overrun) overrun_f <= 1'b1;
    end
  end

  sat_counter #(.W(C_DATA_WIDTH)) u_cycle_cnt (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .clr   (clr_cnt),
    .en    (en_cnt),
    .count (cycle_cnt)
  );

  always_comb begin
    status                              = '0;
    status[ST_BUSY]                     = (state != S_IDLE);
    status[ST_DONE]                     = done_f;
    status[ST_TIMEOUT]                  = timeout_f;
    status[ST_ABORTED]                  = aborted_f;
    status[ST_OVERRUN]                  = overrun_f;
    status[RUNCNT_LSB +: C_RUNCNT_W]    = run_cnt;
  end

endmodule

// File: tb/tb_start_pulse_sequencer.sv
// Bench for start_pulse_sequencer: directed scenarios plus randomized runs
// checked against an edge-count model of each run's outcome.
module tb_start_pulse_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_reg;
  logic        ctrl_wr;
  logic [31:0] param_reg;
  logic [31:0] timeout_reg;
  logic [31:0] status;
  logic [31:0] cycle_cnt;
  logic        irq;
  logic        ap_start;
  logic [31:0] ap_param;
  logic        ap_ready;
  logic        ap_done;

  int n_checks = 0;
  int n_err    = 0;
  int irq_total = 0;
  int exp_run_cnt = 0;
  logic [31:0] last_status = '0;
  logic [31:0] exp_q[$];

  start_pulse_sequencer dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .ctrl_reg        (ctrl_reg),
    .ctrl_wr         (ctrl_wr),
    .param_reg       (param_reg),
    .timeout_reg     (timeout_reg),
    .status          (status),
    .cycle_cnt       (cycle_cnt),
    .irq             (irq),
    .ap_start        (ap_start),
    .ap_param        (ap_param),
    .ap_ready        (ap_ready),
    .ap_done         (ap_done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (irq === 1'b1) irq_total++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Model of one run, measured in clock edges after the accepting edge:
  // cycle_cnt reads k-1 before edge k, so the timeout fires on edge t;
  // done on edge d wins whenever d <= t.
  task automatic run_single(input logic [31:0] p, input int t, input int r, input int d);
    int end_edge, start_hi, hi, irq0;
    bit is_done;
    logic [31:0] exp_s, got_s;
    if (d > 0 && (t == 0 || d <= t)) begin
      is_done = 1'b1; end_edge = d;
    end else begin
      is_done = 1'b0; end_edge = t;
    end
    start_hi = (r > 0 && r < end_edge) ? r : end_edge;
    if (is_done) exp_s = {16'(exp_run_cnt + 1), 16'h0002};
    else         exp_s = {16'(exp_run_cnt), 16'h0004};
    exp_q.push_back(exp_s);

    timeout_reg = 32'(t); param_reg = p; ctrl_reg = 32'h1; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0; param_reg = $urandom;
    irq0 = irq_total;
    n_checks++;
    if (status[4:0] !== 5'b00001) begin
      n_err++; $display("FAIL start_status: got %h expected busy only", status[4:0]);
    end
    n_checks++;
    if (ap_param !== p) begin
      n_err++; $display("FAIL ap_param: got %h expected %h", ap_param, p);
    end
    n_checks++;
    if (cycle_cnt !== 32'd0) begin
      n_err++; $display("FAIL cnt_start: got %0d expected 0", cycle_cnt);
    end
    hi = 0;
    for (int k = 1; k <= end_edge + 2; k++) begin
      if (ap_start === 1'b1) hi++;
      ap_ready = (k == r);
      ap_done  = (k == d);
      @(posedge clk); #1;
    end
    ap_ready = 1'b0; ap_done = 1'b0;
    got_s = exp_q.pop_front();
    n_checks++;
    if (hi != start_hi) begin
      n_err++; $display("FAIL ap_start_len: got %0d expected %0d", hi, start_hi);
    end
    n_checks++;
    if (status !== got_s) begin
      n_err++; $display("FAIL run_status: got %h expected %h", status, got_s);
    end
    n_checks++;
    if (cycle_cnt !== 32'(end_edge)) begin
      n_err++; $display("FAIL latency: got %0d expected %0d", cycle_cnt, end_edge);
    end
    n_checks++;
    if (irq_total - irq0 != 1) begin
      n_err++; $display("FAIL irq_count: got %0d expected 1", irq_total - irq0);
    end
    n_checks++;
    if (ap_param !== p) begin
      n_err++; $display("FAIL ap_param_hold: got %h expected %h", ap_param, p);
    end
    if (is_done) exp_run_cnt++;
    last_status = got_s;
  endtask

  task automatic test_reset();
    int irq0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({status, cycle_cnt, ap_param, ap_start, irq} !== '0) begin
      n_err++; $display("FAIL por_outputs: status=%h cnt=%h param=%h start=%b irq=%b expected all 0",
                        status, cycle_cnt, ap_param, ap_start, irq);
    end
    @(negedge clk); rst_n = 1'b1;
    timeout_reg = 32'd0; param_reg = 32'h77; ctrl_reg = 32'h1; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0; ap_ready = 1'b1;
    @(posedge clk); #1;
    ap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (status[0] !== 1'b1 || cycle_cnt !== 32'd4) begin
      n_err++; $display("FAIL pre_reset_run: busy=%b cnt=%0d expected 1 and 4", status[0], cycle_cnt);
    end
    irq0 = irq_total;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ap_start !== 1'b0 || status !== 32'd0 || cycle_cnt !== 32'd0 || ap_param !== 32'd0) begin
      n_err++; $display("FAIL async_reset: start=%b status=%h cnt=%h param=%h expected 0",
                        ap_start, status, cycle_cnt, ap_param);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (status !== 32'd0 || irq_total != irq0) begin
      n_err++; $display("FAIL post_reset: status=%h irqs=%0d expected 0 and 0", status, irq_total - irq0);
    end
    exp_run_cnt = 0;
    last_status = '0;
  endtask

  task automatic test_basic();
    run_single(32'hA5, 0, 2, 10);
  endtask

  task automatic test_timeout();
    run_single($urandom, 5, 2, 0);
    run_single($urandom, 5, 0, 0);
    run_single($urandom, 5, 3, 5);
  endtask

  task automatic test_abort();
    int irq0;
    irq0 = irq_total;
    ctrl_reg = 32'h3; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ap_start !== 1'b0 || status !== last_status) begin
      n_err++; $display("FAIL start_abort_idle: start=%b status=%h expected 0 and %h",
                        ap_start, status, last_status);
    end
    timeout_reg = 32'd0; ctrl_reg = 32'h1; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0; ap_ready = 1'b1;
    @(posedge clk); #1;
    ap_ready = 1'b0;
    @(posedge clk); #1;
    ctrl_reg = 32'h2; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    last_status = {16'(exp_run_cnt), 16'h0008};
    n_checks++;
    if (ap_start !== 1'b0 || status !== last_status) begin
      n_err++; $display("FAIL abort_run: start=%b status=%h expected 0 and %h", ap_start, status, last_status);
    end
    n_checks++;
    if (irq_total != irq0) begin
      n_err++; $display("FAIL abort_irq: got %0d expected 0", irq_total - irq0);
    end
  endtask

  task automatic test_overrun();
    int irq0;
    timeout_reg = 32'd0; ctrl_reg = 32'h1; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0;
    irq0 = irq_total;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        n_checks++;
        if (status[4] !== 1'b1 || status[0] !== 1'b1) begin
          n_err++; $display("FAIL overrun_flag: overrun=%b busy=%b expected 1 and 1", status[4], status[0]);
        end
      end
      ctrl_wr  = (k == 3);
      ap_ready = (k == 1);
      ap_done  = (k == 6);
      @(posedge clk); #1;
    end
    ctrl_wr = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    exp_run_cnt++;
    last_status = {16'(exp_run_cnt), 16'h0012};
    n_checks++;
    if (status !== last_status || cycle_cnt !== 32'd6 || irq_total - irq0 != 1) begin
      n_err++; $display("FAIL overrun_run: status=%h cnt=%0d irqs=%0d expected %h 6 1",
                        status, cycle_cnt, irq_total - irq0, last_status);
    end
    run_single(32'h1234_5678, 0, 1, 3);
  endtask

  task automatic test_auto_restart();
    logic [31:0] p[3];
    int r, d, irq0;
    foreach (p[i]) p[i] = $urandom;
    timeout_reg = 32'd0; param_reg = p[0]; ctrl_reg = 32'h5; ctrl_wr = 1'b1;
    @(posedge clk); #1;
    ctrl_wr = 1'b0;
    irq0 = irq_total;
    n_checks++;
    if (ap_param !== p[0]) begin
      n_err++; $display("FAIL auto_param0: got %h expected %h", ap_param, p[0]);
    end
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(1, 3);
      d = r + $urandom_range(0, 5);
      for (int k = 1; k <= d; k++) begin
        ap_ready = (k == r);
        ap_done  = (k == d);
        if (i == 2 && k == 1) begin
          ctrl_reg = 32'h0; ctrl_wr = 1'b1;
        end else begin
          ctrl_wr = 1'b0;
        end
        if (i < 2 && k == d) param_reg = p[i+1];
        @(posedge clk); #1;
      end
      ctrl_wr = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
      if (i < 2) begin
        n_checks++;
        if (ap_start !== 1'b1 || status[0] !== 1'b1 || ap_param !== p[i+1] || cycle_cnt !== 32'd0) begin
          n_err++; $display("FAIL auto_restart%0d: start=%b busy=%b param=%h cnt=%0d expected 1 1 %h 0",
                            i, ap_start, status[0], ap_param, cycle_cnt, p[i+1]);
        end
      end else begin
        n_checks++;
        if (ap_start !== 1'b0 || status[0] !== 1'b0 || cycle_cnt !== 32'(d)) begin
          n_err++; $display("FAIL auto_last: start=%b busy=%b cnt=%0d expected 0 0 %0d",
                            ap_start, status[0], cycle_cnt, d);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    exp_run_cnt += 3;
    last_status = {16'(exp_run_cnt), 16'h0002};
    n_checks++;
    if (status !== last_status || irq_total - irq0 != 3) begin
      n_err++; $display("FAIL auto_summary: status=%h irqs=%0d expected %h 3",
                        status, irq_total - irq0, last_status);
    end
  endtask

  task automatic test_random();
    int t, r, d;
    for (int n = 0; n < 20; n++) begin
      t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
      r = $urandom_range(0, 4);
      if (r == 0 || $urandom_range(0, 3) == 0) d = 0;
      else d = r + $urandom_range(0, 12);
      if (t == 0 && d == 0) t = $urandom_range(1, 15);
      run_single($urandom, t, r, d);
    end
  endtask

  initial begin
    rst_n = 1'b0; ctrl_reg = '0; ctrl_wr = 1'b0; param_reg = '0;
    timeout_reg = '0; ap_ready = 1'b0; ap_done = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_abort();
    test_overrun();
    test_auto_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
